// File: rtl/wave_pkg.sv
// Shared wave definitions: sample width, threshold defaults and the
// meter FSM encoding, reused by the generator side.
package wave_pkg;

    localparam int SW = 8;

    typedef logic [SW-1:0] smp_t;

    localparam smp_t MID_DEF  = 8'd128;
    localparam smp_t HYST_DEF = 8'd8;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        SYNC,
        MEAS,
        REPL,
        HOLD
    } state_t;

    function automatic smp_t umin(input smp_t a, input smp_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic smp_t umax(input smp_t a, input smp_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/wave_meter_if.sv
// Sample stream, start request and result handshake of the wave meter.
interface wave_meter_if #(
    parameter int PW = 12
) ();
    import wave_pkg::*;

    smp_t          in;
    logic          in_vld;
    logic          start;
    logic [PW-1:0] period;
    smp_t          vmin;
    smp_t          vmax;
    logic          timeout;
    logic          res_vld;
    logic          res_rdy;
    logic          busy;

    modport master (
        output in, in_vld, start, res_rdy,
        input  period, vmin, vmax, timeout, res_vld, busy
    );

    modport slave (
        input  in, in_vld, start, res_rdy,
        output period, vmin, vmax, timeout, res_vld, busy
    );

endinterface

// File: rtl/wave_meter_hyst_cmp.sv
// Hysteresis threshold compare: flags a sample at/below LO or at/above HI.
module hyst_cmp
    import wave_pkg::*;
#(
    parameter smp_t MID  = MID_DEF,
    parameter smp_t HYST = HYST_DEF
) (
    input  smp_t in,
    output logic le_lo,
    output logic ge_hi
);

    localparam smp_t LO = MID - HYST;
    localparam smp_t HI = MID + HYST;

    assign le_lo = (in <= LO);
    assign ge_hi = (in >= HI);

endmodule

// File: rtl/wave_meter.sv
// Measures one full period of a sampled wave between two rising crossings,
// with min/max over that period and saturating timeout.
module wave_meter
    import wave_pkg::*;
#(
    parameter smp_t MID  = MID_DEF,
    parameter smp_t HYST = HYST_DEF,
    parameter int   PW   = 12
) (
    input logic          clk,
    input logic          rst_n,
    wave_meter_if.slave  bus
);

    localparam logic [PW-1:0] MAXP = '1;
    localparam logic [PW-1:0] ONE  = {{(PW-1){1'b0}}, 1'b1};

    state_t        state;
    logic [PW-1:0] cnt;
    smp_t          acc_min;
    smp_t          acc_max;
    logic [PW-1:0] period_q;
    smp_t          vmin_q;
    smp_t          vmax_q;
    logic          timeout_q;
    logic          res_vld_q;
    logic          busy_q;

    logic          le_lo;
    logic          ge_hi;
    logic          sat;
    logic          has_acc;
    logic [PW-1:0] cnt_inc;
    smp_t          nxt_min;
    smp_t          nxt_max;

    hyst_cmp #(
        .MID  (MID),
        .HYST (HYST)
    ) u_cmp (
        .in    (bus.in),
        .le_lo (le_lo),
        .ge_hi (ge_hi)
    );

    assign sat     = (cnt == MAXP);
    assign has_acc = (state == MEAS) || (state == REPL);
    assign cnt_inc = cnt + ONE;
    assign nxt_min = umin(acc_min, bus.in);
    assign nxt_max = umax(acc_max, bus.in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            acc_min   <= '1;
            acc_max   <= '0;
            period_q  <= '0;
            vmin_q    <= '1;
            vmax_q    <= '0;
            timeout_q <= 1'b0;
            res_vld_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= ARM;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.res_rdy) begin
                        state     <= IDLE;
                        res_vld_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end
                end
                default: begin
                    // Saturation wins over any crossing seen on the same sample.
                    if (bus.in_vld && sat) begin
                        state     <= HOLD;
                        period_q  <= MAXP;
                        timeout_q <= 1'b1;
                        vmin_q    <= has_acc ? acc_min : '0;
                        vmax_q    <= has_acc ? acc_max : '0;
                        res_vld_q <= 1'b1;
                    end else if (bus.in_vld) begin
                        unique case (state)
                            ARM: begin
                                cnt <= cnt_inc;
                                if (le_lo) state <= SYNC;
                            end
                            SYNC: begin
                                if (ge_hi) begin
                                    cnt     <= ONE;
                                    acc_min <= bus.in;
                                    acc_max <= bus.in;
                                    state   <= MEAS;
                                end else begin
                                    cnt <= cnt_inc;
                                end
                            end
                            MEAS: begin
                                cnt     <= cnt_inc;
                                acc_min <= nxt_min;
                                acc_max <= nxt_max;
                                if (le_lo) state <= REPL;
                            end
                            REPL: begin
                                if (ge_hi) begin
                                    state     <= HOLD;
                                    period_q  <= cnt;
                                    timeout_q <= 1'b0;
                                    vmin_q    <= acc_min;
                                    vmax_q    <= acc_max;
                                    res_vld_q <= 1'b1;
                                end else begin
                                    cnt     <= cnt_inc;
                                    acc_min <= nxt_min;
                                    acc_max <= nxt_max;
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign bus.period  = period_q;
    assign bus.vmin    = vmin_q;
    assign bus.vmax    = vmax_q;
    assign bus.timeout = timeout_q;
    assign bus.res_vld = res_vld_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_wave_meter.sv
// Self-checking bench for wave_meter: table vectors, directed corners and
// randomized waves against a window-based reference model.
module tb_wave_meter;

    localparam int PW   = 12;
    localparam int MAXP = 4095;
    localparam int LO   = 120;
    localparam int HI   = 136;

    typedef struct {
        int         term;
        logic [11:0] period;
        logic [7:0] vmin;
        logic [7:0] vmax;
        logic       to;
    } res_t;

    typedef struct {
        int         n;
        int         s [12];
        int         mode;
        logic [11:0] period;
        logic [7:0] vmin;
        logic [7:0] vmax;
        logic       to;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wave_meter_if #(.PW(PW)) bus ();

    wave_meter #(
        .MID  (8'd128),
        .HYST (8'd8),
        .PW   (PW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Locate the arm point, both rising crossings and the falling crossing
    // by index, then derive the result from the window between crossings.
    function automatic res_t model(input logic [7:0] s[$]);
        res_t r;
        int a = -1, st = -1, m = -1, e = -1, stop = 0;
        for (int i = 0; i < s.size(); i++) begin
            if (a < 0) begin
                if (s[i] <= LO) a = i;
            end else if (st < 0) begin
                if (s[i] >= HI) st = i;
            end else if (m < 0) begin
                if (s[i] <= LO) m = i;
            end else if (e < 0) begin
                if (s[i] >= HI) e = i;
            end
        end
        r.period = 12'(MAXP);
        r.to = 1'b1;
        r.vmin = 8'h00;
        r.vmax = 8'h00;
        if (st < 0 || st >= MAXP) begin
            r.term = MAXP;
        end else begin
            if (e < 0 || e - st >= MAXP) begin
                r.term = st + MAXP;
                stop = st + MAXP;
            end else begin
                r.term = e;
                r.period = 12'(e - st);
                r.to = 1'b0;
                stop = e;
            end
            r.vmin = 8'hFF;
            for (int i = st; i < stop && i < s.size(); i++) begin
                if (s[i] < r.vmin) r.vmin = s[i];
                if (s[i] > r.vmax) r.vmax = s[i];
            end
        end
        return r;
    endfunction

    // mode 0: every cycle valid, 1: valid every other cycle, 2: random gaps
    task automatic run_meas(input string name, input logic [7:0] s[$],
                            input int mode, input res_t x, input bit accept);
        bit early = 1'b0;
        int gaps;
        @(negedge clk);
        bus.start = 1'b1;
        bus.in_vld = 1'b0;
        bus.in = 8'($urandom);
        bus.res_rdy = 1'b0;
        @(negedge clk);
        chk({name, ".busy"}, 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        for (int i = 0; i <= x.term; i++) begin
            gaps = (mode == 1) ? 1 :
                   (mode == 2 && $urandom_range(0, 2) == 0) ? 2 : 0;
            for (int g = 0; g < gaps; g++) begin
                bus.in_vld = 1'b0;
                bus.in = 8'($urandom);
                @(negedge clk);
                if (bus.res_vld) early = 1'b1;
            end
            bus.in = s[i];
            bus.in_vld = 1'b1;
            @(negedge clk);
            if (i < x.term && bus.res_vld) early = 1'b1;
        end
        bus.in_vld = 1'b0;
        chk({name, ".early"}, 32'(early), 32'd0);
        chk({name, ".res_vld"}, 32'(bus.res_vld), 32'd1);
        chk({name, ".period"}, 32'(bus.period), 32'(x.period));
        chk({name, ".vmin"}, 32'(bus.vmin), 32'(x.vmin));
        chk({name, ".vmax"}, 32'(bus.vmax), 32'(x.vmax));
        chk({name, ".timeout"}, 32'(bus.timeout), 32'(x.to));
        if (accept) begin
            bus.res_rdy = 1'b1;
            @(negedge clk);
            bus.res_rdy = 1'b0;
            chk({name, ".acc_vld"}, 32'(bus.res_vld), 32'd0);
            chk({name, ".acc_busy"}, 32'(bus.busy), 32'd0);
        end
    endtask

    task automatic gen_wave(output logic [7:0] q[$]);
        bit hi = ($urandom_range(0, 1) == 1);
        int len, r;
        q = {};
        while (q.size() < 300) begin
            len = $urandom_range(1, 30);
            for (int j = 0; j < len; j++) begin
                r = $urandom_range(0, 9);
                if (r < 2) q.push_back(8'($urandom_range(LO + 1, HI - 1)));
                else if (r == 2) q.push_back(hi ? 8'(HI) : 8'(LO));
                else if (hi) q.push_back(8'($urandom_range(HI, 255)));
                else q.push_back(8'($urandom_range(0, LO)));
            end
            hi = !hi;
        end
    endtask

    function automatic void square(output logic [7:0] q[$], input int reps);
        q = {};
        for (int k = 0; k < reps; k++) begin
            for (int j = 0; j < 128; j++) q.push_back(8'd255);
            for (int j = 0; j < 128; j++) q.push_back(8'd0);
        end
    endfunction

    vec_t vt [4];
    logic [7:0] q[$];
    res_t x;
    logic [11:0] h_per;
    logic [7:0] h_min, h_max;
    bit bad;

    initial begin
        vt[0].n = 10;
        vt[0].s = '{0, 130, 0, 140, 200, 50, 130, 0, 120, 140, 0, 0};
        vt[0].mode = 0;
        vt[0].period = 12'd6; vt[0].vmin = 8'd0; vt[0].vmax = 8'd200;
        vt[0].to = 1'b0;
        vt[1].n = 7;
        vt[1].s = '{120, 136, 135, 120, 121, 119, 136, 0, 0, 0, 0, 0};
        vt[1].mode = 1;
        vt[1].period = 12'd5; vt[1].vmin = 8'd119; vt[1].vmax = 8'd136;
        vt[1].to = 1'b0;
        vt[2].n = 8;
        vt[2].s = '{121, 200, 119, 137, 128, 0, 135, 136, 0, 0, 0, 0};
        vt[2].mode = 0;
        vt[2].period = 12'd4; vt[2].vmin = 8'd0; vt[2].vmax = 8'd137;
        vt[2].to = 1'b0;
        vt[3].n = 7;
        vt[3].s = '{255, 0, 255, 255, 0, 0, 255, 0, 0, 0, 0, 0};
        vt[3].mode = 1;
        vt[3].period = 12'd4; vt[3].vmin = 8'd0; vt[3].vmax = 8'd255;
        vt[3].to = 1'b0;

        bus.in = 8'd0;
        bus.in_vld = 1'b0;
        bus.start = 1'b0;
        bus.res_rdy = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.period", 32'(bus.period), 32'd0);
        chk("rst.vmin", 32'(bus.vmin), 32'hFF);
        chk("rst.vmax", 32'(bus.vmax), 32'd0);
        chk("rst.timeout", 32'(bus.timeout), 32'd0);
        chk("rst.res_vld", 32'(bus.res_vld), 32'd0);
        chk("rst.busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            q = {};
            for (int i = 0; i < vt[v].n; i++) q.push_back(8'(vt[v].s[i]));
            x.term = vt[v].n - 1;
            x.period = vt[v].period;
            x.vmin = vt[v].vmin;
            x.vmax = vt[v].vmax;
            x.to = vt[v].to;
            run_meas($sformatf("vec%0d", v), q, vt[v].mode, x, 1'b1);
        end

        // first low at 128 arms sync, rises at 256 and 512
        square(q, 3);
        x.term = 512; x.period = 12'd256;
        x.vmin = 8'd0; x.vmax = 8'd255; x.to = 1'b0;
        run_meas("square", q, 0, x, 1'b1);
        run_meas("square_half", q, 1, x, 1'b1);

        q = {};
        for (int i = 0; i < 4096; i++) q.push_back(8'(i % 128));
        x.term = 4095; x.period = 12'd4095;
        x.vmin = 8'd0; x.vmax = 8'd0; x.to = 1'b1;
        run_meas("ramp_to", q, 0, x, 1'b1);

        square(q, 3);
        x.term = 512; x.period = 12'd256;
        x.vmin = 8'd0; x.vmax = 8'd255; x.to = 1'b0;
        run_meas("hold", q, 0, x, 1'b0);
        h_per = bus.period; h_min = bus.vmin; h_max = bus.vmax;
        bad = 1'b0;
        for (int k = 0; k < 20; k++) begin
            bus.start = (k == 5 || k == 6);
            bus.in = 8'($urandom);
            bus.in_vld = 1'($urandom);
            @(negedge clk);
            if (!bus.res_vld || bus.period !== 12'd256 ||
                bus.vmin !== 8'd0 || bus.vmax !== 8'd255 || !bus.busy)
                bad = 1'b1;
        end
        chk("hold.stable", 32'(bad), 32'd0);
        bus.in_vld = 1'b0;
        bus.res_rdy = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.res_rdy = 1'b0;
        bus.start = 1'b0;
        chk("hold.acc_vld", 32'(bus.res_vld), 32'd0);
        chk("hold.acc_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk("hold.no_rearm", 32'(bus.busy), 32'd0);
        chk("hold.idle_period", 32'(bus.period), 32'd256);

        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.in_vld = 1'b1;
        bus.in = 8'd0;
        @(negedge clk);
        bus.in = 8'd200;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst.res_vld", 32'(bus.res_vld), 32'd0);
        chk("mrst.vmin", 32'(bus.vmin), 32'hFF);
        chk("mrst.vmax", 32'(bus.vmax), 32'd0);
        chk("mrst.busy", 32'(bus.busy), 32'd0);
        chk("mrst.period", 32'(bus.period), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        square(q, 3);
        bad = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            bus.in = q[i];
            @(negedge clk);
            if (bus.res_vld || bus.busy) bad = 1'b1;
        end
        bus.in_vld = 1'b0;
        chk("mrst.no_result", 32'(bad), 32'd0);

        for (int t = 0; t < 10; t++) begin
            do begin
                gen_wave(q);
                x = model(q);
            end while (x.term >= q.size());
            run_meas($sformatf("rand%0d", t), q, $urandom_range(0, 2), x,
                     1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/wave_meter.md
WAVE_METER -- requirements
Module: wave_meter

Interface
REQ-001 Parameter: MID, default 8'd128, the crossing midpoint for sample values.
REQ-002 Parameter: HYST, default 8'd8, the hysteresis half-width; low threshold LO = MID-HYST, high threshold HI = MID+HYST.
REQ-003 Parameter: PW, default 12, the period counter width; MAXP = 2^PW-1.
REQ-004 Port: clk  in  1  single clock; all logic is on the rising edge.
REQ-005 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-006 Port: in  in  8  unsigned sample from the wave generator.
REQ-007 Port: in_vld  in  1  sample qualifier; a sample counts only on cycles where in_vld=1.
REQ-008 Port: start  in  1  level/pulse; arms one measurement when sampled high in IDLE.
REQ-009 Port: period  out  PW  valid samples between two consecutive rising crossings.
REQ-010 Port: vmin, vmax  out  8 each  minimum and maximum sample over the measured period.
REQ-011 Port: timeout  out  1  the result was aborted because the count reached MAXP.
REQ-012 Port: res_vld  out  1  result valid; held until accepted.
REQ-013 Port: res_rdy  in  1  consumer accept.
REQ-014 Port: busy  out  1  high in every state except IDLE.

Function
REQ-015 FSM states SHALL be IDLE, ARM, SYNC, MEAS, REPL, HOLD; state advances only on in_vld=1 cycles, except the IDLE->ARM and HOLD->IDLE transitions.
REQ-016 IDLE: on start=1, SHALL go to ARM on the next cycle; all other inputs are ignored.
REQ-017 ARM: SHALL wait for a valid sample with in<=LO, then go to SYNC.
REQ-018 SYNC: on the first valid sample with in>=HI (rising crossing), SHALL load cnt=1, vmin=vmax=in, and go to MEAS.
REQ-019 MEAS: each valid sample SHALL increment cnt and update vmin/vmax (unsigned compare); on in<=LO, SHALL go to REPL.
REQ-020 REPL: each valid sample with in<HI SHALL increment cnt and update vmin/vmax; a valid sample with in>=HI (second rising crossing) SHALL NOT be counted or included, SHALL set period=cnt and timeout=0, and SHALL go to HOLD.
REQ-021 Samples strictly between LO and HI SHALL NOT cause any transition (hysteresis).
REQ-022 In ARM, SYNC, MEAS and REPL, if cnt==MAXP when a valid sample arrives, the FSM SHALL go to HOLD with period=MAXP, timeout=1, and vmin/vmax as accumulated so far (0/0 if still in ARM or SYNC).
REQ-023 HOLD: res_vld=1, with period/vmin/vmax/timeout stable; on res_vld&&res_rdy, SHALL go to IDLE on the next cycle, with res_vld=0 that cycle.
REQ-024 start SHALL be ignored outside IDLE; start high in the same cycle as the HOLD acceptance SHALL NOT re-arm the block (one idle cycle minimum).
REQ-025 Result outputs SHALL hold their last value in IDLE and update only on HOLD entry.
REQ-026 The cnt increment SHALL never wrap; it saturates via REQ-022.
REQ-027 Latency: res_vld SHALL rise on the cycle after the terminating sample.

Reset
REQ-028 With rst_n=0, asynchronously: state=IDLE, cnt=0, period=0, vmin=8'hFF, vmax=0, timeout=0, res_vld=0, busy=0.
REQ-029 Reset asserted mid-measurement SHALL discard the measurement; after deassertion the block SHALL wait for start.

Structure
REQ-030 The FSM state enum, the MID/HYST defaults and the sample width 8 SHALL live in the shared wave package, to be reused by the generator side.
REQ-031 The block SHALL be a single module, with one sub-module, hyst_cmp, producing the registered-free le_lo/ge_hi flags.

Verification
REQ-032 Square stream (255 x128, 0 x128, in_vld=1), start -> res_vld with period=256, vmin=0, vmax=255, timeout=0.
REQ-033 Ramp 0..127 repeating (max below HI=136), start -> timeout=1, period=4095 after 4095 valid samples following ARM entry.
REQ-034 Square from REQ-032 with in_vld toggling 1/0 -> period=256; the cycle count doubles, the result is identical.
REQ-035 A sample sequence 0, 130, 0, 140 (130 inside the hysteresis band) -> 130 does not trigger; SYNC fires on 140.
REQ-036 res_rdy held low 20 cycles in HOLD -> outputs stable; start pulsed during HOLD is ignored; accept -> IDLE, busy=0.
REQ-037 rst_n pulsed low in MEAS -> next cycle res_vld=0, vmin=FF, vmax=0; no result appears without a new start.
